// File: rtl/mos6502_rmw_seq.sv
// rtl/mos6502_rmw_seq.sv - 6502 read-modify-write bus sequencer driving the shared ALU.
// Optional NMOS dummy-write MOD cycle enabled by defining MOS6502_DUMMY_WRITE_EN.
module mos6502_rmw_seq #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_en,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] ea,
  input  logic              c_in,
  input  logic              rdy,
  input  logic [7:0]        d_in,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        d_out,
  output logic              rw,
  output logic [3:0]        alu_func,
  output logic [7:0]        alu_b,
  output logic              alu_cin,
  input  logic [7:0]        alu_res,
  input  logic              alu_c,
  input  logic              alu_z,
  input  logic              alu_n,
  output logic              busy,
  output logic              done,
  output logic              flag_we,
  output logic              c_out,
  output logic              z_out,
  output logic              n_out
);

  localparam logic [3:0] ALU_PASS = 4'h0;
  localparam logic [3:0] ALU_INC  = 4'h8;
  localparam logic [3:0] ALU_DEC  = 4'h9;
  localparam logic [3:0] ALU_ASL  = 4'hA;
  localparam logic [3:0] ALU_LSR  = 4'hB;
  localparam logic [3:0] ALU_ROL  = 4'hC;
  localparam logic [3:0] ALU_ROR  = 4'hD;

`ifdef MOS6502_DUMMY_WRITE_EN
  localparam bit DUMMY_WRITE = 1'b1;
`else
  localparam bit DUMMY_WRITE = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, READ, MOD, WRITE} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] ea_q;
  logic [2:0]        op_q;
  logic              cin_q;
  logic [7:0]        data_q;
  logic [7:0]        res_q;
  logic              op_ok;

  function automatic logic [3:0] alu_code(input logic [2:0] o);
    case (o)
      3'd0:    alu_code = ALU_INC;
      3'd1:    alu_code = ALU_DEC;
      3'd2:    alu_code = ALU_ASL;
      3'd3:    alu_code = ALU_LSR;
      3'd4:    alu_code = ALU_ROL;
      3'd5:    alu_code = ALU_ROR;
      default: alu_code = ALU_PASS;
    endcase
  endfunction

  assign op_ok = (op <= 3'd5);

  // Outputs depend only on registered state, so clk_en = 0 freezes them.
  always_comb begin
    state_nx = state;
    addr     = '0;
    rw       = 1'b1;
    d_out    = 8'h00;
    alu_func = ALU_PASS;
    alu_b    = 8'h00;
    alu_cin  = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    flag_we  = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start && op_ok) state_nx = READ;
      end
      READ: begin
        addr = ea_q;
        if (rdy) state_nx = MOD;
      end
      MOD: begin
        addr     = ea_q;
        alu_b    = data_q;
        alu_func = alu_code(op_q);
        alu_cin  = cin_q;
        if (DUMMY_WRITE) begin
          rw       = 1'b0;
          d_out    = data_q;
          state_nx = WRITE;
        end else if (rdy) begin
          state_nx = WRITE;
        end
      end
      WRITE: begin
        addr     = ea_q;
        rw       = 1'b0;
        d_out    = res_q;
        done     = 1'b1;
        flag_we  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ea_q   <= '0;
      op_q   <= 3'd0;
      cin_q  <= 1'b0;
      data_q <= 8'h00;
      res_q  <= 8'h00;
      c_out  <= 1'b0;
      z_out  <= 1'b0;
      n_out  <= 1'b0;
    end else if (clk_en) begin
      state <= state_nx;
      if (state == IDLE && state_nx == READ) begin
        ea_q  <= ea;
        op_q  <= op;
        cin_q <= c_in;
      end
      if (state == READ && state_nx == MOD) data_q <= d_in;
      if (state == MOD && state_nx == WRITE) begin
        res_q <= alu_res;
        c_out <= alu_c;
        z_out <= alu_z;
        n_out <= alu_n;
      end
    end
  end

endmodule

// File: tb/tb_mos6502_rmw_seq.sv
// tb/tb_mos6502_rmw_seq.sv - randomized self-checking bench for mos6502_rmw_seq.
// Adapts expected MOD bus behaviour to MOS6502_DUMMY_WRITE_EN.
module tb_mos6502_rmw_seq;

`ifdef MOS6502_DUMMY_WRITE_EN
  localparam bit DUMMY = 1'b1;
`else
  localparam bit DUMMY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_en = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [15:0] ea = 16'h0;
  logic        c_in = 1'b0;
  logic        rdy = 1'b1;
  logic [7:0]  d_in = 8'h00;
  logic [15:0] addr;
  logic [7:0]  d_out;
  logic        rw;
  logic [3:0]  alu_func;
  logic [7:0]  alu_b;
  logic        alu_cin;
  logic [7:0]  alu_res;
  logic        alu_c, alu_z, alu_n;
  logic        busy, done, flag_we, c_out, z_out, n_out;

  int checks = 0;
  int failures = 0;

  mos6502_rmw_seq #(.ADDR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .start(start), .op(op), .ea(ea),
    .c_in(c_in), .rdy(rdy), .d_in(d_in), .addr(addr), .d_out(d_out), .rw(rw),
    .alu_func(alu_func), .alu_b(alu_b), .alu_cin(alu_cin), .alu_res(alu_res),
    .alu_c(alu_c), .alu_z(alu_z), .alu_n(alu_n), .busy(busy), .done(done),
    .flag_we(flag_we), .c_out(c_out), .z_out(z_out), .n_out(n_out)
  );

  always #5 clk = ~clk;

  // Shared ALU stand-in
  always_comb begin
    alu_res = alu_b;
    alu_c   = alu_cin;
    case (alu_func)
      4'h8: begin alu_res = alu_b + 8'd1; alu_c = 1'b0; end
      4'h9: begin alu_res = alu_b - 8'd1; alu_c = 1'b0; end
      4'hA: {alu_c, alu_res} = {alu_b, 1'b0};
      4'hB: {alu_res, alu_c} = {1'b0, alu_b};
      4'hC: {alu_c, alu_res} = {alu_b, alu_cin};
      4'hD: {alu_res, alu_c} = {alu_cin, alu_b};
      default: ;
    endcase
    alu_z = (alu_res == 8'h00);
    alu_n = alu_res[7];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] func_of(input int o);
    logic [3:0] tbl [6] = '{4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD};
    return tbl[o];
  endfunction

  // One operation: nr read stalls, nm MOD stalls (MOD stalls apply only without dummy write)
  task automatic run_op(input int o, input logic [15:0] a, input int m, input int ci,
                        input int nr, input int nm);
    int t, res, c, nread, nmod, total, lat, stalls;
    logic [43:0] snap;
    case (o)
      0: begin t = m + 1;            c = 0;     end
      1: begin t = m + 255;          c = 0;     end
      2: begin t = m * 2;            c = m / 128; end
      3: begin t = m / 2;            c = m % 2; end
      4: begin t = m * 2 + ci;       c = m / 128; end
      default: begin t = m / 2 + ci * 128; c = m % 2; end
    endcase
    res = t % 256;
    nread = nr + 1;
    nmod = DUMMY ? 1 : nm + 1;
    total = nread + nmod + 1;
    stalls = nr + (DUMMY ? 0 : nm);
    op = 3'(o); ea = a; c_in = ci[0]; d_in = 8'(m); rdy = 1'b1; clk_en = 1'b1; start = 1'b1;
    tick();
    lat = 1;
    start = 1'b0; op = 3'($urandom_range(0, 5)); ea = 16'($urandom); c_in = 1'($urandom);
    for (int k = 0; k < total; k++) begin
      for (int g = 0; g < 2 && $urandom_range(0, 3) == 0; g++) begin
        snap = {addr, rw, d_out, busy, done, flag_we, c_out, z_out, n_out, alu_func, alu_b, alu_cin};
        clk_en = 1'b0; rdy = 1'($urandom); d_in = 8'($urandom); start = 1'($urandom);
        tick();
        start = 1'b0;
        check("hold", {20'h0, addr, rw, d_out, busy, done, flag_we, c_out, z_out, n_out,
                       alu_func, alu_b, alu_cin} >> 12,
              {20'h0, snap} >> 12);
        check("hold_lo", {20'h0, alu_func, alu_b, alu_cin}, {20'h0, snap[12:0]});
      end
      clk_en = 1'b1;
      check("addr", addr, a);
      check("busy", busy, 1);
      if (k < nread) begin
        check("rd_rw", rw, 1);
        check("rd_done", done, 0);
        rdy = (k == nread - 1);
        d_in = rdy ? 8'(m) : 8'($urandom);
      end else if (k < nread + nmod) begin
        check("mod_rw", rw, DUMMY ? 0 : 1);
        check("mod_dout", d_out, DUMMY ? m : 0);
        check("mod_func", alu_func, func_of(o));
        check("mod_b", alu_b, m);
        check("mod_cin", alu_cin, ci);
        check("mod_done", done, 0);
        rdy = DUMMY ? 1'($urandom) : (k == nread + nmod - 1);
        d_in = 8'($urandom);
      end else begin
        check("wr_rw", rw, 0);
        check("wr_dout", d_out, res);
        check("wr_done", done, 1);
        check("wr_fwe", flag_we, 1);
        check("latency", lat, 3 + stalls);
        rdy = 1'($urandom);
      end
      tick();
      lat++;
    end
    check("end_busy", busy, 0);
    check("end_done", done, 0);
    check("end_rw", rw, 1);
    check("z_out", z_out, res == 0);
    check("n_out", n_out, res / 128);
    if (o >= 2) check("c_out", c_out, c);
  endtask

  initial begin
    int dones, zero_writes;
    logic prev_done;
    #2;
    check("rst_busy", busy, 0);
    check("rst_rw", rw, 1);
    check("rst_addr", addr, 0);
    check("rst_flags", {c_out, z_out, n_out}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run_op(2, 16'h0070, 8'h81, 0, 0, 0);   // ASL 81 -> 02, C=1
    check("asl_c", c_out, 1);
    run_op(5, 16'h1234, 8'h01, 1, 0, 0);   // ROR with carry in -> 80
    run_op(1, 16'h0200, 8'h01, 0, 2, 0);   // DEC with two read stalls
    check("dec_z", z_out, 1);
    run_op(4, 16'hFFFF, 8'h80, 0, 1, 2);
    run_op(3, 16'h0000, 8'h01, 1, 0, 1);

    // reserved op is ignored
    op = 3'd6; start = 1'b1; clk_en = 1'b1; tick();
    check("rsv6_busy", busy, 0);
    op = 3'd7; tick();
    check("rsv7_busy", busy, 0);
    start = 1'b0;

    for (int i = 0; i < 40; i++)
      run_op($urandom_range(0, 5), 16'($urandom), $urandom_range(0, 255), $urandom_range(0, 1),
             $urandom_range(0, 2), $urandom_range(0, 2));

    // reset during MOD abandons the op
    run_op(4, 16'h0010, 8'h80, 0, 0, 0);
    op = 3'd2; ea = 16'h0040; d_in = 8'h81; rdy = 1'b1; clk_en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_rw", rw, 1);
    check("arst_addr", addr, 0);
    check("arst_fwe", flag_we, 0);
    check("arst_dout", d_out, 0);
    check("arst_flags", {c_out, z_out, n_out}, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_fwe", flag_we, 0);
      check("post_rst_rw", rw, 1);
    end

    // start held high: back-to-back INC of FF, one idle cycle between ops
    op = 3'd0; ea = 16'h0300; d_in = 8'hFF; c_in = 1'b0; rdy = 1'b1; start = 1'b1;
    dones = 0; zero_writes = 0; prev_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (prev_done) check("gap_busy", busy, 0);
      if (done) begin
        dones++;
        if (!rw && d_out == 8'h00) zero_writes++;
      end
      prev_done = done;
    end
    start = 1'b0;
    check("held_dones", dones, 3);
    check("held_writes", zero_writes, 3);
    check("held_z", z_out, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
